// File: rtl/pif_reg_arb_pkg.sv
// pif_reg_arb_pkg - definitions shared by the PIF register-bus arbiter.
//   XIrec        : register-bus command record (write strobe, address, data,
//                  read sub-address)
//   addresses    : writable registers, the ID readback register and its
//                  sub-address enumeration
//   arb_state_t  : arbiter sequencing states
//   PIF_RD_LAT   : readback pipeline depth of the register block
package pif_reg_arb_pkg;

  localparam int PIF_AW     = 8;
  localparam int PIF_RD_LAT = 4;
  localparam int PIF_IW     = 2;   // width of requester index / pointer

  typedef struct packed {
    logic              PWr;
    logic [PIF_AW-1:0] PRWA;
    logic [7:0]        PD;
    logic [7:0]        PRdSubA;
  } XIrec;

  localparam logic [PIF_AW-1:0] W_SCRATCH_REG = 8'h10;
  localparam logic [PIF_AW-1:0] W_MISC_REG    = 8'h11;
  localparam logic [PIF_AW-1:0] R_ID          = 8'h20;

  typedef enum logic [7:0] {
    R_ID_CHIP    = 8'h00,
    R_ID_MISC    = 8'h01,
    R_ID_SCRATCH = 8'h02
  } r_id_suba_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WRITE = 2'd1,
    ARB_READ  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  // Round-robin pointer after granting requester idx.
  function automatic logic [PIF_IW-1:0] pif_arb_next_ptr(input logic [PIF_IW-1:0] idx,
                                                          input int nreq);
    return PIF_IW'((int'(idx) + 1) % nreq);
  endfunction

endpackage

// File: rtl/pif_arb_pick.sv
// pif_arb_pick - combinational winner selection for the PIF register bus.
//   req     in  : per-requester request bits
//   ptr     in  : round-robin start index (ignored in fixed-priority build)
//   gnt_oh  out : one-hot winner (all zero when no request)
//   gnt_idx out : encoded winner index
// Build option: PIF_ARB_RR_EN selects round-robin; otherwise lowest index wins.
module pif_arb_pick
  import pif_reg_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]   req,
  input  logic [PIF_IW-1:0] ptr,
  output logic [NREQ-1:0]   gnt_oh,
  output logic [PIF_IW-1:0] gnt_idx
);

`ifdef PIF_ARB_RR_EN
  always_comb begin
    int   cand;
    logic found;
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    // Scan starting at the pointer so every requester gets a turn within NREQ grants.
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = PIF_IW'(cand);
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    // Descending scan so the lowest requesting index overwrites last.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        gnt_idx   = PIF_IW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/pif_reg_arb.sv
// pif_reg_arb - shares the PIF register write/readback port between NREQ
// requesters. Each grant becomes a single-cycle write pulse or a held-address
// read whose data is captured after the register block's readback latency.
//   xclk, xrst_n        : clock, asynchronous active-low reset
//   req/we/addr/suba/wdata : per-requester command, packed, requester 0 in LSBs
//   ack, rdata          : completion pulse to the granted requester, read data
//   XI, XO              : register-bus command out, readback in
//   busy, gnt_id        : transaction in progress, current/last winner
// Build option: PIF_ARB_RR_EN enables round-robin arbitration (fixed priority otherwise).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | bus parked on IDLE_ADDR, waiting for a request
// ARB_WRITE | PWr high for this one cycle with latched address/data
// ARB_READ  | address/sub-address held, counting down the readback latency
// ARB_DONE  | ack pulse to the winner, bus parked again
module pif_reg_arb
  import pif_reg_arb_pkg::*;
#(
  parameter int            NREQ      = 2,
  parameter int            AW        = PIF_AW,
  parameter int            RD_LAT    = PIF_RD_LAT,
  parameter logic [AW-1:0] IDLE_ADDR = '0
) (
  input  logic              xclk,
  input  logic              xrst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*8-1:0] suba,
  input  logic [NREQ*8-1:0] wdata,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rdata,
  output XIrec              XI,
  input  logic [7:0]        XO,
  output logic              busy,
  output logic [1:0]        gnt_id
);

  // Keep the width legal for RD_LAT = 0 so the check below is what reports it.
  localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  if (RD_LAT < 1) begin : g_bad_rd_lat
    $error("pif_reg_arb: RD_LAT must be at least 1");
  end
  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("pif_reg_arb: NREQ must be 2..4");
  end
  if (AW != PIF_AW) begin : g_bad_aw
    $error("pif_reg_arb: AW must match the PRWA width");
  end

  arb_state_t        state_q, state_d;
  XIrec              xi_q, xi_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   gnt_oh_q, gnt_oh_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [PIF_IW-1:0] gnt_id_q, gnt_id_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   pick_oh;
  logic [PIF_IW-1:0] pick_idx;
  logic [PIF_IW-1:0] ptr;

`ifdef PIF_ARB_RR_EN
  logic [PIF_IW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  pif_arb_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    xi_d       = xi_q;
    xi_d.PWr   = 1'b0;
    cnt_d      = cnt_q;
    ack_d      = '0;
    gnt_oh_d   = gnt_oh_q;
    rdata_d    = rdata_q;
    gnt_id_d   = gnt_id_q;
`ifdef PIF_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          gnt_id_d  = pick_idx;
          gnt_oh_d  = pick_oh;
          xi_d.PRWA = addr[int'(pick_idx)*AW +: AW];
`ifdef PIF_ARB_RR_EN
          ptr_d     = pif_arb_next_ptr(pick_idx, NREQ);
`endif
          if (we[pick_idx]) begin
            xi_d.PWr = 1'b1;
            xi_d.PD  = wdata[int'(pick_idx)*8 +: 8];
            state_d  = ARB_WRITE;
          end else begin
            xi_d.PRdSubA = suba[int'(pick_idx)*8 +: 8];
            cnt_d        = CW'(RD_LAT);
            state_d      = ARB_READ;
          end
        end
      end
      ARB_WRITE: begin
        xi_d.PRWA = IDLE_ADDR;
        ack_d     = gnt_oh_q;
        state_d   = ARB_DONE;
      end
      ARB_READ: begin
        if (cnt_q == '0) begin
          rdata_d      = XO;
          ack_d        = gnt_oh_q;
          xi_d.PRWA    = IDLE_ADDR;
          xi_d.PRdSubA = '0;
          state_d      = ARB_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge xclk or negedge xrst_n) begin
    if (!xrst_n) begin
      state_q      <= ARB_IDLE;
      xi_q.PWr     <= 1'b0;
      xi_q.PRWA    <= IDLE_ADDR;
      xi_q.PD      <= '0;
      xi_q.PRdSubA <= '0;
      cnt_q        <= '0;
      ack_q        <= '0;
      gnt_oh_q     <= '0;
      rdata_q      <= '0;
      gnt_id_q     <= '0;
      busy_q       <= 1'b0;
`ifdef PIF_ARB_RR_EN
      ptr_q        <= '0;
`endif
    end else begin
      state_q  <= state_d;
      xi_q     <= xi_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      gnt_oh_q <= gnt_oh_d;
      rdata_q  <= rdata_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
`ifdef PIF_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign XI     = xi_q;
  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_pif_reg_arb.sv
// tb_pif_reg_arb - directed self-checking bench for pif_reg_arb with a small
// register-block stub (scratch and misc registers, ID readback, RD_LAT-deep
// readback pipeline).
module tb_pif_reg_arb;
  import pif_reg_arb_pkg::*;

  localparam int            NREQ      = 2;
  localparam int            AW        = 8;
  localparam int            RD_LAT    = PIF_RD_LAT;
  localparam logic [AW-1:0] IDLE_ADDR = 8'h00;

  logic              xclk;
  logic              xrst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*8-1:0] suba;
  logic [NREQ*8-1:0] wdata;
  logic [NREQ-1:0]   ack;
  logic [7:0]        rdata;
  XIrec              xi;
  logic [7:0]        xo;
  logic              busy;
  logic [1:0]        gnt_id;

  int n_chk = 0;
  int n_err = 0;

  pif_reg_arb #(
    .NREQ(NREQ), .AW(AW), .RD_LAT(RD_LAT), .IDLE_ADDR(IDLE_ADDR)
  ) dut (
    .xclk(xclk), .xrst_n(xrst_n), .req(req), .we(we), .addr(addr),
    .suba(suba), .wdata(wdata), .ack(ack), .rdata(rdata), .XI(xi),
    .XO(xo), .busy(busy), .gnt_id(gnt_id)
  );

  initial xclk = 1'b0;
  always #5 xclk = ~xclk;

  // Register-block stub: scratch reads back with bit 6 flipped, misc as 0x5<misc>.
  logic [7:0] scr_m;
  logic [7:0] misc_m;
  logic [7:0] rb;
  logic [7:0] rb_pipe [RD_LAT];

  initial begin
    scr_m  = 8'h00;
    misc_m = 8'h00;
  end

  always @(posedge xclk) begin
    if (xi.PWr && xi.PRWA == W_SCRATCH_REG) scr_m  <= xi.PD;
    if (xi.PWr && xi.PRWA == W_MISC_REG)    misc_m <= xi.PD;
  end

  always_comb begin
    rb = 8'h00;
    if (xi.PRWA == R_ID) begin
      case (xi.PRdSubA)
        R_ID_CHIP:    rb = 8'hA5;
        R_ID_MISC:    rb = {4'h5, misc_m[3:0]};
        R_ID_SCRATCH: rb = scr_m ^ 8'h40;
        default:      rb = 8'h00;
      endcase
    end
  end

  always @(posedge xclk) begin
    rb_pipe[0] <= rb;
    for (int i = 1; i < RD_LAT; i++) rb_pipe[i] <= rb_pipe[i-1];
  end
  assign xo = rb_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge xclk);
    #1;
  endtask

  // Cycle 0 is the cycle in which IDLE sees the request.
  task automatic do_write(input int id, input logic [7:0] a, input logic [7:0] d,
                          input bit drop);
    req[id] = 1'b1;
    we[id]  = 1'b1;
    addr[id*AW +: AW] = a;
    wdata[id*8 +: 8]  = d;
    tick();
    chk("wr_c1_pwr",  32'(xi.PWr), 1);
    chk("wr_c1_prwa", 32'(xi.PRWA), 32'(a));
    chk("wr_c1_pd",   32'(xi.PD), 32'(d));
    chk("wr_c1_gnt",  32'(gnt_id), 32'(id));
    chk("wr_c1_ack",  32'(ack), 0);
    if (drop) req[id] = 1'b0;
    tick();
    chk("wr_c2_pwr",  32'(xi.PWr), 0);
    chk("wr_c2_ack",  32'(ack), 32'(1 << id));
    chk("wr_c2_prwa", 32'(xi.PRWA), 32'(IDLE_ADDR));
    req[id] = 1'b0;
    tick();
    chk("wr_c3_ack",  32'(ack), 0);
    chk("wr_c3_busy", 32'(busy), 0);
  endtask

  task automatic do_read(input int id, input logic [7:0] a, input logic [7:0] sa,
                         input logic [7:0] exp);
    bit hold_ok;
    req[id] = 1'b1;
    we[id]  = 1'b0;
    addr[id*AW +: AW] = a;
    suba[id*8 +: 8]   = sa;
    hold_ok = 1'b1;
    for (int c = 1; c <= RD_LAT + 1; c++) begin
      tick();
      if (c == 1) chk("rd_c1_gnt", 32'(gnt_id), 32'(id));
      if (xi.PRWA !== a || xi.PRdSubA !== sa || xi.PWr !== 1'b0 ||
          ack !== '0 || busy !== 1'b1) hold_ok = 1'b0;
    end
    chk("rd_hold", 32'(hold_ok), 1);
    tick();
    chk("rd_ack",   32'(ack), 32'(1 << id));
    chk("rd_data",  32'(rdata), 32'(exp));
    chk("rd_prwa",  32'(xi.PRWA), 32'(IDLE_ADDR));
    chk("rd_suba",  32'(xi.PRdSubA), 0);
    req[id] = 1'b0;
    tick();
    chk("rd_end_ack",  32'(ack), 0);
    chk("rd_end_busy", 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   bad;
    int   waited;
    int   exp_id;
    req = '0; we = '0; addr = '0; suba = '0; wdata = '0;
    xrst_n = 1'b1;
    #3 xrst_n = 1'b0;
    #1;
    chk("rst_pwr",   32'(xi.PWr), 0);
    chk("rst_prwa",  32'(xi.PRWA), 32'(IDLE_ADDR));
    chk("rst_busy",  32'(busy), 0);
    chk("rst_ack",   32'(ack), 0);
    chk("rst_rdata", 32'(rdata), 0);
    repeat (3) tick();
    xrst_n = 1'b1;

    // Idle with no requests.
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (xi.PWr !== 1'b0 || xi.PRWA !== IDLE_ADDR || ack !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("idle_20", 32'(bad), 0);

    do_write(0, W_SCRATCH_REG, 8'h2A, 1'b0);
    do_write(1, W_MISC_REG, 8'h03, 1'b0);
    do_read(0, R_ID, R_ID_SCRATCH, 8'h6A);
    do_read(1, R_ID, R_ID_MISC, 8'h53);

    // Request withdrawn in cycle 1: write lands and ack still pulses once.
    do_write(0, W_SCRATCH_REG, 8'h11, 1'b1);
    tick();
    chk("drop_no_2nd_ack", 32'(ack), 0);
    do_read(1, R_ID, R_ID_SCRATCH, 8'h51);

    // Contention: both requesters keep reading.
    we = '0;
    addr = {R_ID, R_ID};
    suba = {8'(R_ID_MISC), 8'(R_ID_CHIP)};
    req  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      tick();
      while (ack == '0 && waited < 20) begin
        tick();
        waited++;
      end
      chk("cont_ack_seen", 32'(ack != '0), 1);
      if (ack == '0) break;
`ifdef PIF_ARB_RR_EN
      exp_id = k % 2;
`else
      exp_id = 0;
`endif
      chk("cont_ack",   32'(ack), 32'(1 << exp_id));
      chk("cont_rdata", 32'(rdata), (exp_id == 1) ? 32'h53 : 32'hA5);
      if (k == 3) req = '0;
    end
    req = '0;
    tick();
    chk("cont_end_busy", 32'(busy), 0);

    // Reset in cycle 3 of a read.
    we[0] = 1'b0;
    addr[0 +: AW] = R_ID;
    suba[0 +: 8]  = R_ID_SCRATCH;
    req[0] = 1'b1;
    repeat (3) tick();
    chk("mid_busy_pre", 32'(busy), 1);
    xrst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy), 0);
    chk("mid_rst_pwr",   32'(xi.PWr), 0);
    chk("mid_rst_prwa",  32'(xi.PRWA), 32'(IDLE_ADDR));
    chk("mid_rst_suba",  32'(xi.PRdSubA), 0);
    chk("mid_rst_pd",    32'(xi.PD), 0);
    chk("mid_rst_ack",   32'(ack), 0);
    chk("mid_rst_gnt",   32'(gnt_id), 0);
    chk("mid_rst_rdata", 32'(rdata), 0);
    req = '0;
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (ack !== '0) bad = 1'b1;
    end
    xrst_n = 1'b1;
    repeat (6) begin
      tick();
      if (ack !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("mid_rst_no_ack", 32'(bad), 0);
    do_read(1, R_ID, R_ID_CHIP, 8'hA5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
